inst_fetch: RTL

- Fetch-side initiator for the combinational instruction memory: holds the PC, drives a byte address each cycle, captures the returned word.
- Hands the captured word to decode through a single-entry valid/ready output register.
- Supports PC redirect (branch/jump), halt, and misaligned-redirect fault.
- Sits between the instruction memory and the decode stage in npc.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_next_pc.sv | 28 ++
 rtl/inst_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } ifu_state_e;

  // Takes only the two low address bits, since nothing else decides alignment.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC selection: hold, sequential advance, or redirect target.
// Also reports whether a requested redirect target is misaligned.
module ifu_next_pc
  import ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect_ok,
  output logic            redirect_bad
);

  // A misaligned redirect leaves the PC where it was.
  always_comb begin
    redirect_ok  = redirect_en && is_word_aligned(redirect_pc[1:0]);
    redirect_bad = redirect_en && !is_word_aligned(redirect_pc[1:0]);
    if (redirect_ok) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = pc + 32'd4;
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// hands one captured word at a time to decode over valid/ready.
module inst_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic handoff_s;
  logic redirect_en_s;
  logic load_s;
  logic redirect_ok_s;
  logic redirect_bad_s;

  assign handoff_s     = valid_q && id_ready;
  assign redirect_en_s = redirect_valid && ((state_q == BOOT) || (state_q == RUN));
  // Redirect and halt both suppress the capture in the cycle they arrive.
  assign load_s        = (state_q == RUN) && !redirect_valid && !halt
                         && (!valid_q || id_ready);

  ifu_next_pc u_next_pc (
    .pc           (pc_q),
    .advance      (load_s),
    .redirect_en  (redirect_en_s),
    .redirect_pc  (redirect_pc),
    .next_pc      (pc_d),
    .redirect_ok  (redirect_ok_s),
    .redirect_bad (redirect_bad_s)
  );

  // Next-state logic for the FSM and the decode-facing output register.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    err_d     = err_q;
    // A handoff completes even in the cycle that flushes the slot.
    cnt_d     = handoff_s ? (cnt_q + 32'd1) : cnt_q;

    if (redirect_ok_s) begin
      valid_d   = 1'b0;
      if_inst_d = NOP_INST;
      state_d   = RUN;
    end else if (redirect_bad_s) begin
      valid_d   = 1'b0;
      if_inst_d = NOP_INST;
      err_d     = 1'b1;
      state_d   = FAULT;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN: begin
          if (halt) begin
            state_d = HALTED;
            if (handoff_s) begin
              valid_d   = 1'b0;
              if_inst_d = NOP_INST;
            end else begin
              valid_d = valid_q;
            end
          end else if (load_s) begin
            valid_d   = 1'b1;
            if_pc_d   = pc_q;
            if_inst_d = inst_data;
          end else begin
            valid_d = valid_q;
          end
        end
        HALTED, FAULT: begin
          if (handoff_s) begin
            valid_d   = 1'b0;
            if_inst_d = NOP_INST;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          state_d = FAULT;
        end
      endcase
    end
  end

  // State, PC and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= PC_RESET;
      valid_q   <= 1'b0;
      if_pc_q   <= 32'h0000_0000;
      if_inst_q <= NOP_INST;
      err_q     <= 1'b0;
      cnt_q     <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign inst_addr    = pc_q;
  assign if_valid     = valid_q;
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign misalign_err = err_q;
  assign fetch_cnt    = cnt_q;

endmodule
